// File: rtl/dest_filter_pipe.sv
// dest_filter_pipe: per-destination ingress filter for the shared-memory switch.
// Each input slot is matched against DEST (binary index or multicast mask),
// matches flow through a per-port LAT-deep collapsing pipeline with valid/ready
// backpressure, and non-matches are consumed and dropped immediately.
// Optional statistics counters are built when FILTER_STATS_EN is defined.

module dest_filter_pipe #(
  parameter int PORT_NUB   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEST       = 0,
  parameter int LAT        = 2,
  parameter int MCAST      = 0,
  parameter int CNT_W      = 16,
  localparam int SEL_W = $clog2(PORT_NUB),
  localparam int RX_W  = (MCAST != 0) ? PORT_NUB : SEL_W,
  localparam int W_IN  = 1 + RX_W + SEL_W + DATA_WIDTH,
  localparam int W_OUT = 2 * SEL_W + DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORT_NUB*W_IN-1:0]  port_in,
  output logic [PORT_NUB-1:0]       in_ready,
  output logic [PORT_NUB*W_OUT-1:0] port_out,
  output logic [PORT_NUB-1:0]       port_valid,
  input  logic [PORT_NUB-1:0]       out_ready
`ifdef FILTER_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [PORT_NUB*CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0]          drop_cnt
`endif
);

  localparam int PL_W = SEL_W + DATA_WIDTH;
  localparam logic [SEL_W-1:0] DEST_SEL = SEL_W'(DEST);

  logic [PORT_NUB-1:0] in_valid;
  logic [PORT_NUB-1:0] hit;
  logic [PORT_NUB-1:0] match;
  logic [PORT_NUB-1:0] adv0;
  logic [PORT_NUB-1:0] head_v;
  logic [RX_W-1:0]     rx      [PORT_NUB];
  logic [PL_W-1:0]     pl_in   [PORT_NUB];
  logic [PL_W-1:0]     head_pl [PORT_NUB];

  // Split each input slot into valid, rx field and {tx, data} payload
  always_comb begin
    for (int unsigned i = 0; i < PORT_NUB; i++) begin
      in_valid[i] = port_in[i*W_IN + W_IN - 1];
      rx[i]       = port_in[i*W_IN + PL_W +: RX_W];
      pl_in[i]    = port_in[i*W_IN +: PL_W];
    end
  end

  generate
    if (MCAST != 0) begin : g_mcast
      logic [PORT_NUB-1:0] unused_rx;
      // Multicast mask: this destination's bit selects the slot
      always_comb begin
        for (int unsigned i = 0; i < PORT_NUB; i++) begin
          hit[i]       = rx[i][DEST];
          unused_rx[i] = ^rx[i];
        end
      end
    end else begin : g_ucast
      // Binary destination index compare
      always_comb begin
        for (int unsigned i = 0; i < PORT_NUB; i++) begin
          hit[i] = (rx[i] == DEST_SEL);
        end
      end
    end
  endgenerate

  // Forward only valid hits that do not loop back to their source port
  always_comb begin
    for (int unsigned i = 0; i < PORT_NUB; i++) begin
      match[i] = in_valid[i] & hit[i] & (pl_in[i][DATA_WIDTH +: SEL_W] != DEST_SEL);
    end
  end

  generate
    if (LAT == 0) begin : g_comb
      logic unused_clk;
      assign unused_clk = clk ^ rst;
      // No stages: the live input is the head and readiness follows the sink
      always_comb begin
        head_v = match;
        adv0   = out_ready;
        for (int unsigned i = 0; i < PORT_NUB; i++) begin
          head_pl[i] = pl_in[i];
        end
      end
    end else begin : g_pipe
      logic            v_q  [PORT_NUB][LAT];
      logic            v_d  [PORT_NUB][LAT];
      logic [PL_W-1:0] pl_q [PORT_NUB][LAT];
      logic [PL_W-1:0] pl_d [PORT_NUB][LAT];
      logic            adv  [PORT_NUB][LAT];

      // Advance chain is built from the head backwards so an empty stage
      // anywhere lets everything behind it move up (bubbles collapse)
      always_comb begin
        for (int unsigned i = 0; i < PORT_NUB; i++) begin
          for (int unsigned k = 0; k < LAT; k++) begin
            adv[i][k]  = 1'b0;
            v_d[i][k]  = v_q[i][k];
            pl_d[i][k] = pl_q[i][k];
          end
        end
        for (int unsigned i = 0; i < PORT_NUB; i++) begin
          adv[i][LAT-1] = !v_q[i][LAT-1] | out_ready[i];
          for (int unsigned j = 1; j < LAT; j++) begin
            adv[i][LAT-1-j] = !v_q[i][LAT-1-j] | adv[i][LAT-j];
          end
          if (adv[i][0]) begin
            v_d[i][0]  = match[i];
            pl_d[i][0] = pl_in[i];
          end
          for (int unsigned k = 1; k < LAT; k++) begin
            if (adv[i][k]) begin
              v_d[i][k]  = v_q[i][k-1];
              pl_d[i][k] = pl_q[i][k-1];
            end
          end
        end
      end

      // Stage registers; reset discards every in-flight entry
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < PORT_NUB; i++) begin
            for (int unsigned k = 0; k < LAT; k++) begin
              v_q[i][k]  <= 1'b0;
              pl_q[i][k] <= '0;
            end
          end
        end else begin
          v_q  <= v_d;
          pl_q <= pl_d;
        end
      end

      // Head of each chain is the last stage
      always_comb begin
        for (int unsigned i = 0; i < PORT_NUB; i++) begin
          head_v[i]  = v_q[i][LAT-1];
          head_pl[i] = pl_q[i][LAT-1];
          adv0[i]    = adv[i][0];
        end
      end
    end
  endgenerate

  // Output presentation: zero-gated payload, drop path always ready
  always_comb begin
    in_ready   = adv0 | ~match;
    port_valid = head_v;
    port_out   = '0;
    for (int unsigned i = 0; i < PORT_NUB; i++) begin
      if (head_v[i]) begin
        port_out[i*W_OUT +: W_OUT] = {DEST_SEL, head_pl[i]};
      end
    end
  end

`ifdef FILTER_STATS_EN
  logic [CNT_W-1:0] mcnt_q [PORT_NUB];
  logic [CNT_W-1:0] mcnt_d [PORT_NUB];
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] drop_d;
  logic             drop_evt;

  // Saturating counters; clear has priority over increment
  always_comb begin
    drop_evt = |(in_valid & ~match);
    drop_d   = drop_q;
    if (stats_clr) begin
      drop_d = '0;
    end else if (drop_evt && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
    match_cnt = '0;
    for (int unsigned i = 0; i < PORT_NUB; i++) begin
      mcnt_d[i] = mcnt_q[i];
      if (stats_clr) begin
        mcnt_d[i] = '0;
      end else if (match[i] && adv0[i] && (mcnt_q[i] != '1)) begin
        mcnt_d[i] = mcnt_q[i] + CNT_W'(1);
      end
      match_cnt[i*CNT_W +: CNT_W] = mcnt_q[i];
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      for (int unsigned i = 0; i < PORT_NUB; i++) begin
        mcnt_q[i] <= '0;
      end
    end else begin
      drop_q <= drop_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: doc/dest_filter_pipe.md
Name: dest_filter_pipe

Overview:
- Per-destination ingress filter for the shared-memory switch, one instance per output port.
- Successor to the fixed unicast filter: adds a selectable multicast mask mode, a configurable pipeline depth with per-port valid/ready backpressure, and optional statistics counters.
- Sits between the input crossbar bus and the per-destination write arbiter.

Parameters:
- PORT_NUB, 8, number of switch ports; must be ≥2.
- DATA_WIDTH, 32, payload width.
- DEST, 0, index of the output port this instance serves; range 0..PORT_NUB-1.
- LAT, 2, pipeline register stages; range 0..4.
- MCAST, 0:
  - 0 = rx field is a binary index of SEL_W bits.
  - 1 = rx field is a one-hot/multi-hot mask of PORT_NUB bits.
- CNT_W, 16, statistics counter width.
- Derived widths:
  - SEL_W = $clog2(PORT_NUB)
  - RX_W = MCAST ? PORT_NUB : SEL_W
  - W_IN = 1+RX_W+SEL_W+DATA_WIDTH
  - W_OUT = 2*SEL_W+DATA_WIDTH

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous reset, active-high.
- port_in, input, PORT_NUB*W_IN. Slot i is {valid, rx, tx, data}, with slot 0 at the LSBs.
- in_ready, output, PORT_NUB. Slot i is accepted when valid & in_ready[i].
- port_out, output, PORT_NUB*W_OUT. Slot i is {DEST[SEL_W-1:0], tx, data}.
- port_valid, output, PORT_NUB, output slot i holds a match.
- out_ready, input, PORT_NUB, downstream accepts slot i.
- stats_clr, input, 1, synchronous clear of all counters. Present only with the optional feature.
- match_cnt, output, PORT_NUB*CNT_W, per-port accepted-match count. Present only with the optional feature.
- drop_cnt, output, CNT_W, filtered-out count. Present only with the optional feature.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. Every register updates only on the rising edge of clk.
- Match rule for slot i:
  - MCAST=0: hit = (rx == DEST).
  - MCAST=1: hit = rx[DEST].
  - match = valid & hit & (tx != DEST). Loopback is never forwarded.
- Filtered entries (valid & !match):
  - in_ready[i]=1 for them regardless of backpressure.
  - They are consumed and discarded in the same cycle.
  - They never occupy a pipeline stage.
- Ports are independent. Each slot has its own LAT-deep stage chain with one valid bit per stage.
  - No cross-port arbitration.
  - No reordering within a port.
- LAT=0:
  - Purely combinational.
  - port_valid[i]=match.
  - in_ready[i]=out_ready[i] | !match.
- LAT≥1: stage k advances when it is empty or stage k+1 advances. The last stage advances when it is empty or out_ready[i]=1.
  - Bubbles collapse.
  - in_ready[i]=advance(stage 0) | !match.
  - Fill latency is LAT cycles from acceptance to port_valid.
  - Throughput is 1 per cycle per port when out_ready is held at 1.
- Payload presentation:
  - Output payload = {DEST, tx, data} of the head entry.
  - When port_valid[i]=0 the slot is driven all zeros.
  - Payload registers may be enabled only on advance. The zero-gating applies at the output.
- Output stability: once port_valid[i]=1, slot i and port_valid[i] hold stable until out_ready[i]=1.
- Reset:
  - All stage valids clear; port_valid=0; port_out=0.
  - in_ready reflects the empty pipe on the first post-reset cycle: 1 for LAT≥1; out_ready|!match for LAT=0.
  - Reset mid-stream discards all in-flight entries with no partial output.
- Full pipe with out_ready=0: in_ready[i]=0 for matching input. Non-matching input is still dropped (in_ready=1).
- Full pipe with simultaneous out_ready=1 and a new match: the head is consumed, the chain shifts, and the new entry is accepted in the same cycle.

Optional Feature:
- Macro: FILTER_STATS_EN.
- When defined:
  - match_cnt[i] increments on each accepted match.
  - drop_cnt increments by one per cycle in which any slot has valid & !match. It is an event-cycle count, not a popcount.
  - Both counters saturate at all-ones.
  - stats_clr zeros all counters. If clear and increment coincide, the clear wins and the counter reads 0.
  - rst zeros all counters.
- When undefined: stats_clr, match_cnt and drop_cnt ports and all counter logic are absent. All other behaviour is identical.

Test Plan:
1. PORT_NUB=8, DEST=3, MCAST=0, LAT=2, out_ready=1; slot 5 sends {1,3'd3,3'd5,32'hA5A5_0001} → port_valid[5]=1 exactly 2 cycles later; slot 5 out = {3'd3,3'd5,32'hA5A5_0001}; other slots 0.
2. Loopback/miss: slot 3 sends rx=3,tx=3, and slot 1 sends rx=6 → in_ready=1 for both; port_valid never asserts; drop_cnt=1 (one cycle) with FILTER_STATS_EN.
3. MCAST=1, DEST=2; slot 0 sends rx=8'b0000_0110 and slot 4 sends rx=8'b0000_0001 → only slot 0 forwarded; slot 4 dropped.
4. Backpressure, LAT=2, out_ready[5]=0; slot 5 streams 4 matches back to back → 2 accepted, then in_ready[5]=0. Raise out_ready → remaining entries emerge in order, 1 per cycle, with no loss or duplication.
5. Reset mid-stream: with 2 entries in flight, assert rst 1 cycle → next cycle port_valid=0 and port_out=0; no stale entries emerge afterwards.
6. FILTER_STATS_EN, CNT_W=4: 17 matches on slot 7 → match_cnt[7]=4'hF (saturated). stats_clr asserted in the same cycle as a match → match_cnt[7]=0.
